reg_file: RTL and testbench

//   MIPS_Lite general-purpose register file. Sits directly upstream of ALU_Src.
//   - Rt_data feeds the ALU_Src mux, alongside Imm.
//   - Rs_data feeds the ALU A operand directly.
//   - Two combinational read ports, one synchronous write port (write-back stage).
//   - Register 0 is hard-wired to zero.

---
 rtl/reg_file.sv | 70 +++++++
 tb/tb_reg_file.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// MIPS_Lite register file: two combinational read ports, one write port committed on the rising clk edge; r0 reads as zero.
// No backpressure. Define REG_FILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] Rs_addr,
   input  logic [ADDR_WIDTH-1:0] Rt_addr,
   output logic [DATA_WIDTH-1:0] Rs_data,
   output logic [DATA_WIDTH-1:0] Rt_data,
   input  logic                  Reg_write,
   input  logic [ADDR_WIDTH-1:0] Wr_addr,
   input  logic [DATA_WIDTH-1:0] Wr_data,
   output logic                  Wr_ignored
);

   // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

   // r0 has no storage at all; its reads are the zero default below.
   logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
   logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
   logic                  wr_ignored_q;
   logic                  wr_ignored_d;
   logic                  wr_legal;

   always_comb begin
      wr_legal     = Reg_write && (Wr_addr != '0) && ({1'b0, Wr_addr} < NUM_REGS_W);
      wr_ignored_d = Reg_write && !wr_legal;
      regs_d       = regs_q;
      if (wr_legal) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (Wr_addr == ADDR_WIDTH'(i)) regs_d[i] = Wr_data;
         end
      end
   end

   always_comb begin
      Rs_data = '0;
      Rt_data = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (Rs_addr == ADDR_WIDTH'(i)) Rs_data = regs_q[i];
         if (Rt_addr == ADDR_WIDTH'(i)) Rt_data = regs_q[i];
      end
`ifdef REG_FILE_BYPASS_EN
      // Gated by rst so both ports stay zero throughout reset.
      if (!rst && wr_legal) begin
         if (Rs_addr == Wr_addr) Rs_data = Wr_data;
         if (Rt_addr == Wr_addr) Rt_data = Wr_data;
      end
`else
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_ignored_q <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         wr_ignored_q <= wr_ignored_d;
      end
   end

   assign Wr_ignored = wr_ignored_q;

endmodule

// File: tb/tb_reg_file.sv
// Randomised bench for reg_file: a full-size instance and a 5-register instance share stimulus,
// each checked against an array model that follows the register-file rules directly.
module tb_reg_file;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst;
   logic [2:0] rs_a, rt_a, wr_a;
   logic [7:0] wr_d;
   logic       we;
   logic [7:0] rs_o [2];
   logic [7:0] rt_o [2];
   logic       ig_o [2];

   int         n_checks = 0;
   int         n_errors = 0;

   // Model: register values per instance, number of registers, expected Wr_ignored.
   logic [7:0] mdl [2][8];
   int         nr  [2] = '{8, 5};
   logic       ign [2];

   initial forever #5 clk = clk_en ? ~clk : 1'b0;

   reg_file #(.DATA_WIDTH(8), .NUM_REGS(8), .ADDR_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .Rs_addr(rs_a), .Rt_addr(rt_a),
      .Rs_data(rs_o[0]), .Rt_data(rt_o[0]), .Reg_write(we),
      .Wr_addr(wr_a), .Wr_data(wr_d), .Wr_ignored(ig_o[0])
   );

   reg_file #(.DATA_WIDTH(8), .NUM_REGS(5), .ADDR_WIDTH(3)) dut5 (
      .clk(clk), .rst(rst), .Rs_addr(rs_a), .Rt_addr(rt_a),
      .Rs_data(rs_o[1]), .Rt_data(rt_o[1]), .Reg_write(we),
      .Wr_addr(wr_a), .Wr_data(wr_d), .Wr_ignored(ig_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit legal(input int k, input logic [2:0] a);
      return we && a != 3'd0 && int'(a) < nr[k];
   endfunction

   function automatic logic [7:0] exp_rd(input int k, input logic [2:0] a);
      if (rst) return 8'd0;
`ifdef REG_FILE_BYPASS_EN
      if (legal(k, wr_a) && a == wr_a) return wr_d;
`endif
      if (a == 3'd0 || int'(a) >= nr[k]) return 8'd0;
      return mdl[k][a];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 8; r++) mdl[k][r] = 8'd0;
         ign[k] = 1'b0;
      end
   endtask

   task automatic check_reads(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_rs%0d", tag, k), rs_o[k], exp_rd(k, rs_a));
         chk($sformatf("%s_rt%0d", tag, k), rt_o[k], exp_rd(k, rt_a));
      end
   endtask

   // One clock cycle: drive at negedge, check reads before and after the rising edge.
   task automatic cyc(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb, input string tag);
      @(negedge clk);
      we = w; wr_a = wa; wr_d = wd; rs_a = ra; rt_a = rb;
      #1 check_reads({tag, "_pre"});
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            if (legal(k, wr_a)) mdl[k][wr_a] = wr_d;
            ign[k] = we && !legal(k, wr_a);
         end
      end
      #1;
      for (int k = 0; k < 2; k++) chk($sformatf("%s_ign%0d", tag, k), ig_o[k], ign[k]);
      check_reads({tag, "_post"});
   endtask

   logic       alu_src_cntrl;
   logic [7:0] imm, to_alu;

   initial begin
      rst = 1'b1; we = 1'b0; wr_a = 3'd0; wr_d = 8'd0; rs_a = 3'd3; rt_a = 3'd5;
      alu_src_cntrl = 1'b0; imm = 8'h3C;
      model_reset();
      #3;
      chk("rst_rs", rs_o[0], 8'd0);
      chk("rst_rt", rt_o[0], 8'd0);
      chk("rst_ign", ig_o[0], 1'b0);
      rst = 1'b0;
      #2 clk_en = 1'b1;
      for (int a = 0; a < 8; a++) cyc(1'b0, 3'd0, 8'd0, 3'(a), 3'(7 - a), "after_rst");

      cyc(1'b1, 3'd1, 8'd2, 3'd0, 3'd0, "wr_r1");
      cyc(1'b1, 3'd2, 8'd16, 3'd0, 3'd0, "wr_r2");
      cyc(1'b0, 3'd0, 8'd0, 3'd1, 3'd2, "rd_12");
      chk("r1_r2_rs", rs_o[0], 8'd2);
      chk("r1_r2_rt", rt_o[0], 8'd16);
      cyc(1'b0, 3'd0, 8'd0, 3'd2, 3'd1, "rd_21");
      chk("swap_rs", rs_o[0], 8'd16);
      chk("swap_rt", rt_o[0], 8'd2);

      cyc(1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, "wr_r0");
      chk("r0_ign", ig_o[0], 1'b1);
      chk("r0_rd", rs_o[0], 8'd0);
      cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd0, "idle");
      chk("ign_clr", ig_o[0], 1'b0);
      cyc(1'b1, 3'd6, 8'h44, 3'd6, 3'd5, "oob_wr");
      chk("oob5_ign", ig_o[1], 1'b1);
      chk("oob8_ign", ig_o[0], 1'b0);

      cyc(1'b1, 3'd4, 8'd6, 3'd0, 3'd0, "wr_r4");
      @(negedge clk);
      we = 1'b1; wr_a = 3'd4; wr_d = 8'd8; rt_a = 3'd4; rs_a = 3'd0;
`ifdef REG_FILE_BYPASS_EN
      #1 chk("rdw_byp", rt_o[0], 8'd8);
`else
      #1 chk("rdw_old", rt_o[0], 8'd6);
`endif
      @(posedge clk);
      mdl[0][4] = 8'd8; mdl[1][4] = 8'd8; ign[0] = 1'b0; ign[1] = 1'b0;
      cyc(1'b0, 3'd0, 8'd0, 3'd0, 3'd4, "rdw_after");
      chk("rdw_new", rt_o[0], 8'd8);

      cyc(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, "wr_r3");
      @(negedge clk);
      we = 1'b1; wr_a = 3'd3; wr_d = 8'h5A; rs_a = 3'd3; rt_a = 3'd3;
      #2 rst = 1'b1;
      model_reset();
      #1 chk("arst_rs", rs_o[0], 8'd0);
      check_reads("arst_now");
      for (int e = 0; e < 2; e++) begin
         @(posedge clk);
         #1 check_reads("arst_hold");
         chk("arst_ign", ig_o[0], 1'b0);
      end
      @(negedge clk);
      rst = 1'b0; we = 1'b0;
      cyc(1'b0, 3'd0, 8'd0, 3'd3, 3'd3, "arst_rel");
      chk("r3_cleared", rs_o[0], 8'd0);

      cyc(1'b1, 3'd6, 8'd7, 3'd0, 3'd0, "wr_r6");
      cyc(1'b0, 3'd0, 8'd0, 3'd6, 3'd6, "rd_66");
      chk("r6_rs", rs_o[0], 8'd7);
      chk("r6_rt", rt_o[0], 8'd7);
      to_alu = alu_src_cntrl ? imm : rt_o[0];
      chk("to_alu", to_alu, 8'd7);

      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
